// File: rtl/gs_pipe_ctrl.sv
// GoldenSnitch pipeline control: boot/fetch sequencing, PC redirect, per-stage
// flush/halt generation, operand-forward selection and a stall watchdog.
module gs_pipe_ctrl #(
   parameter int NUM_FWD   = 2,
   parameter int FWD_SEL_W = $clog2(NUM_FWD+1),
   parameter int MAX_STALL = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 if_fetch_valid_i,
   input  logic                 id_ready_i,
   input  logic                 id_jump_i,
   input  logic                 ex_br_taken_i,
   input  logic                 ex_ready_i,
   input  logic                 trap_i,
   input  logic                 load_to_use_i,
   input  logic [NUM_FWD-1:0]   rs1_hit_i,
   input  logic [NUM_FWD-1:0]   rs2_hit_i,
   output logic [FWD_SEL_W-1:0] rs1_fwd_sel_o,
   output logic [FWD_SEL_W-1:0] rs2_fwd_sel_o,
   output logic [2:0]           pc_mux_sel_o,
   output logic                 pc_set_o,
   output logic                 instr_fetch_o,
   output logic                 is_decoding_o,
   output logic                 flush_if_o,
   output logic                 flush_id_o,
   output logic                 flush_ex_o,
   output logic                 halt_if_o,
   output logic                 halt_id_o,
   output logic                 halt_ex_o,
   output logic                 stall_timeout_o
);

   typedef enum logic [1:0] {
      S_RESET,
      S_BOOT_SET,
      S_WAIT_FETCH,
      S_DECODE
   } state_t;

   typedef enum logic [2:0] {
      PC_BOOT   = 3'd0,
      PC_NORMAL = 3'd1,
      PC_JUMP   = 3'd2,
      PC_BRANCH = 3'd3,
      PC_TRAP   = 3'd4
   } pc_sel_t;

   localparam int               CNT_W       = $clog2(MAX_STALL+1);
   localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(MAX_STALL);

   state_t           state_q, state_d;
   logic             ex_stall, lu_stall, any_stall;
   logic             any_halt;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // An unfinished EX op outranks load-to-use: the bubble only goes in once EX has moved.
   assign ex_stall  = !ex_ready_i;
   assign lu_stall  = ex_ready_i && load_to_use_i;
   assign any_stall = ex_stall || lu_stall;
   assign any_halt  = halt_if_o || halt_id_o || halt_ex_o;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values; combinational blocks use blocking (=).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_RESET;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every output and state_d gets a default first, so no path through
   // the case below can leave one unassigned and infer a latch.
   always_comb begin
      state_d       = state_q;
      pc_mux_sel_o  = PC_NORMAL;
      pc_set_o      = 1'b0;
      instr_fetch_o = 1'b0;
      is_decoding_o = 1'b0;
      flush_if_o    = 1'b0;
      flush_id_o    = 1'b0;
      flush_ex_o    = 1'b0;
      halt_if_o     = 1'b0;
      halt_id_o     = 1'b0;
      halt_ex_o     = 1'b0;

      case (state_q)
         S_RESET: begin
            pc_mux_sel_o = PC_BOOT;
            state_d      = S_BOOT_SET;
         end

         S_BOOT_SET: begin
            pc_set_o      = 1'b1;
            pc_mux_sel_o  = PC_BOOT;
            instr_fetch_o = 1'b1;
            state_d       = S_WAIT_FETCH;
         end

         S_WAIT_FETCH: begin
            instr_fetch_o = 1'b1;
            if (trap_i) begin
               pc_set_o     = 1'b1;
               pc_mux_sel_o = PC_TRAP;
               flush_if_o   = 1'b1;
               flush_id_o   = 1'b1;
               flush_ex_o   = 1'b1;
            end else if (if_fetch_valid_i && id_ready_i) begin
               state_d = S_DECODE;
            end
         end

         S_DECODE: begin
            instr_fetch_o = 1'b1;
            if (trap_i) begin
               pc_set_o     = 1'b1;
               pc_mux_sel_o = PC_TRAP;
               flush_if_o   = 1'b1;
               flush_id_o   = 1'b1;
               flush_ex_o   = 1'b1;
               state_d      = S_WAIT_FETCH;
            end else if (ex_br_taken_i && ex_ready_i) begin
               pc_set_o     = 1'b1;
               pc_mux_sel_o = PC_BRANCH;
               flush_if_o   = 1'b1;
               flush_id_o   = 1'b1;
               state_d      = S_WAIT_FETCH;
            end else if (id_jump_i && !any_stall) begin
               pc_set_o     = 1'b1;
               pc_mux_sel_o = PC_JUMP;
               flush_if_o   = 1'b1;
               flush_id_o   = 1'b1;
               state_d      = S_WAIT_FETCH;
            end else begin
               is_decoding_o = !any_stall;
               if (ex_stall) begin
                  halt_if_o = 1'b1;
                  halt_id_o = 1'b1;
                  halt_ex_o = 1'b1;
               end else if (lu_stall) begin
                  halt_if_o  = 1'b1;
                  halt_id_o  = 1'b1;
                  flush_ex_o = 1'b1;
               end
            end
         end

         default: state_d = S_RESET;
      endcase
   end

   // Youngest matching stage wins; walking from the oldest lets it overwrite.
   always_comb begin
      rs1_fwd_sel_o = '0;
      rs2_fwd_sel_o = '0;
      for (int k = NUM_FWD-1; k >= 0; k--) begin
         if (rs1_hit_i[k]) rs1_fwd_sel_o = FWD_SEL_W'(k+1);
         if (rs2_hit_i[k]) rs2_fwd_sel_o = FWD_SEL_W'(k+1);
      end
   end

   always_comb begin
      stall_cnt_d = '0;
      if (any_halt) begin
         stall_cnt_d = (stall_cnt_q == STALL_LIMIT) ? stall_cnt_q : stall_cnt_q + 1'b1;
      end
   end

   // The flag is raised on the same edge that loads STALL_LIMIT into the counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q     <= '0;
         stall_timeout_o <= 1'b0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         if (stall_cnt_d == STALL_LIMIT) begin
            stall_timeout_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_gs_pipe_ctrl.sv
// Self-checking bench for gs_pipe_ctrl: directed corner sequences, a forwarding
// vector table and a randomized run against a behavioural model.
module tb_gs_pipe_ctrl;

   localparam int NUM_FWD   = 3;
   localparam int FWD_SEL_W = 2;
   localparam int MAX_STALL = 4;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 if_fetch_valid_i, id_ready_i, id_jump_i, ex_br_taken_i;
   logic                 ex_ready_i, trap_i, load_to_use_i;
   logic [NUM_FWD-1:0]   rs1_hit_i, rs2_hit_i;
   logic [FWD_SEL_W-1:0] rs1_fwd_sel_o, rs2_fwd_sel_o;
   logic [2:0]           pc_mux_sel_o;
   logic                 pc_set_o, instr_fetch_o, is_decoding_o;
   logic                 flush_if_o, flush_id_o, flush_ex_o;
   logic                 halt_if_o, halt_id_o, halt_ex_o, stall_timeout_o;

   gs_pipe_ctrl #(
      .NUM_FWD  (NUM_FWD),
      .MAX_STALL(MAX_STALL)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .if_fetch_valid_i(if_fetch_valid_i),
      .id_ready_i      (id_ready_i),
      .id_jump_i       (id_jump_i),
      .ex_br_taken_i   (ex_br_taken_i),
      .ex_ready_i      (ex_ready_i),
      .trap_i          (trap_i),
      .load_to_use_i   (load_to_use_i),
      .rs1_hit_i       (rs1_hit_i),
      .rs2_hit_i       (rs2_hit_i),
      .rs1_fwd_sel_o   (rs1_fwd_sel_o),
      .rs2_fwd_sel_o   (rs2_fwd_sel_o),
      .pc_mux_sel_o    (pc_mux_sel_o),
      .pc_set_o        (pc_set_o),
      .instr_fetch_o   (instr_fetch_o),
      .is_decoding_o   (is_decoding_o),
      .flush_if_o      (flush_if_o),
      .flush_id_o      (flush_id_o),
      .flush_ex_o      (flush_ex_o),
      .halt_if_o       (halt_if_o),
      .halt_id_o       (halt_id_o),
      .halt_ex_o       (halt_ex_o),
      .stall_timeout_o (stall_timeout_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] f1, f2;
      logic [2:0] mux;
      logic       set, fetch, dec, fif, fid, fex, hif, hid, hex, to;
   } outs_t;

   typedef struct {
      logic [2:0] h1, h2;
      logic [1:0] e1, e2;
   } fwd_vec_t;

   outs_t      dut_o;
   logic [11:0] dut_ctl;
   assign dut_o   = {rs1_fwd_sel_o, rs2_fwd_sel_o, pc_mux_sel_o, pc_set_o, instr_fetch_o,
                     is_decoding_o, flush_if_o, flush_id_o, flush_ex_o, halt_if_o,
                     halt_id_o, halt_ex_o, stall_timeout_o};
   assign dut_ctl = {pc_set_o, pc_mux_sel_o, instr_fetch_o, is_decoding_o,
                     flush_if_o, flush_id_o, flush_ex_o, halt_if_o, halt_id_o, halt_ex_o};

   int total = 0;
   int bad   = 0;

   // Model state: which phase of the boot/fetch/decode sequence we are in.
   int m_phase;   // 0 reset, 1 boot, 2 waiting for fetch, 3 decoding
   int m_run;     // consecutive halt cycles seen, capped at MAX_STALL
   bit m_to;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected control vector: {set, mux, fetch, dec, flush if/id/ex, halt if/id/ex}.
   task automatic exp_ctl(input string name, input logic set, input logic [2:0] mux,
                          input logic fetch, input logic dec, input logic [2:0] fl,
                          input logic [2:0] hl);
      check(name, 32'(dut_ctl), 32'({set, mux, fetch, dec, fl, hl}));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   task automatic idle_in();
      if_fetch_valid_i = 1'b1;
      id_ready_i       = 1'b1;
      id_jump_i        = 1'b0;
      ex_br_taken_i    = 1'b0;
      ex_ready_i       = 1'b1;
      trap_i           = 1'b0;
      load_to_use_i    = 1'b0;
      rs1_hit_i        = '0;
      rs2_hit_i        = '0;
   endtask

   function automatic logic [1:0] first_hit(input logic [2:0] h);
      for (int i = 0; i < NUM_FWD; i++) begin
         if (h[i]) return 2'(i + 1);
      end
      return 2'd0;
   endfunction

   task automatic predict(output outs_t e);
      e     = '0;
      e.f1  = first_hit(rs1_hit_i);
      e.f2  = first_hit(rs2_hit_i);
      e.mux = 3'd1;
      e.to  = m_to;
      if (!rst) begin
         e.mux = 3'd0;
         e.to  = 1'b0;
         return;
      end
      if (m_phase == 0) begin
         e.mux = 3'd0;
      end else if (m_phase == 1) begin
         e.set = 1'b1; e.mux = 3'd0; e.fetch = 1'b1;
      end else begin
         e.fetch = 1'b1;
         if (trap_i) begin
            e.set = 1'b1; e.mux = 3'd4; e.fif = 1'b1; e.fid = 1'b1; e.fex = 1'b1;
         end else if (m_phase == 3) begin
            if (ex_br_taken_i && ex_ready_i) begin
               e.set = 1'b1; e.mux = 3'd3; e.fif = 1'b1; e.fid = 1'b1;
            end else if (id_jump_i && ex_ready_i && !load_to_use_i) begin
               e.set = 1'b1; e.mux = 3'd2; e.fif = 1'b1; e.fid = 1'b1;
            end else if (!ex_ready_i) begin
               e.hif = 1'b1; e.hid = 1'b1; e.hex = 1'b1;
            end else if (load_to_use_i) begin
               e.hif = 1'b1; e.hid = 1'b1; e.fex = 1'b1;
            end else begin
               e.dec = 1'b1;
            end
         end
      end
   endtask

   task automatic advance(input outs_t e);
      if (!rst) return;
      case (m_phase)
         0: m_phase = 1;
         1: m_phase = 2;
         2: if (!trap_i && if_fetch_valid_i && id_ready_i) m_phase = 3;
         default: if (e.set) m_phase = 2;
      endcase
      if (e.hif || e.hid || e.hex) m_run = (m_run < MAX_STALL) ? m_run + 1 : MAX_STALL;
      else m_run = 0;
      if (m_run == MAX_STALL) m_to = 1'b1;
   endtask

   // Asserts rst mid-cycle, checks the immediate reset state, then releases it
   // so the following sample is cycle 1 after reset.
   task automatic do_reset(input string tag);
      step();
      rst = 1'b0;
      idle_in();
      samp();
      exp_ctl({tag, "_in_reset"}, 1'b0, 3'd0, 1'b0, 1'b0, 3'b000, 3'b000);
      check({tag, "_timeout_cleared"}, 32'(stall_timeout_o), 32'd0);
      step();
      rst = 1'b1;
   endtask

   // Drives from reset release into DECODE with fetch valid/ready held high.
   task automatic boot(input string tag);
      do_reset(tag);
      samp();
      exp_ctl({tag, "_cyc1"}, 1'b0, 3'd0, 1'b0, 1'b0, 3'b000, 3'b000);
      step(); samp();
      exp_ctl({tag, "_cyc2_boot_set"}, 1'b1, 3'd0, 1'b1, 1'b0, 3'b000, 3'b000);
      step(); samp();
      exp_ctl({tag, "_cyc3_wait"}, 1'b0, 3'd1, 1'b1, 1'b0, 3'b000, 3'b000);
      step(); samp();
      exp_ctl({tag, "_cyc4_decode"}, 1'b0, 3'd1, 1'b1, 1'b1, 3'b000, 3'b000);
   endtask

   fwd_vec_t fwd_tab[6];
   outs_t    e;

   initial begin
      idle_in();
      fwd_tab[0] = '{h1: 3'b110, h2: 3'b000, e1: 2'd2, e2: 2'd0};
      fwd_tab[1] = '{h1: 3'b001, h2: 3'b111, e1: 2'd1, e2: 2'd1};
      fwd_tab[2] = '{h1: 3'b000, h2: 3'b100, e1: 2'd0, e2: 2'd3};
      fwd_tab[3] = '{h1: 3'b100, h2: 3'b010, e1: 2'd3, e2: 2'd2};
      fwd_tab[4] = '{h1: 3'b101, h2: 3'b011, e1: 2'd1, e2: 2'd1};
      fwd_tab[5] = '{h1: 3'b010, h2: 3'b110, e1: 2'd2, e2: 2'd2};

      // Boot sequence, then branch beats a simultaneous jump.
      boot("boot");
      check("boot_timeout_low", 32'(stall_timeout_o), 32'd0);
      step(); ex_br_taken_i = 1'b1; id_jump_i = 1'b1; samp();
      exp_ctl("branch_over_jump", 1'b1, 3'd3, 1'b1, 1'b0, 3'b110, 3'b000);
      step(); idle_in(); samp();
      exp_ctl("after_branch_wait", 1'b0, 3'd1, 1'b1, 1'b0, 3'b000, 3'b000);
      step(); samp();
      exp_ctl("after_branch_decode", 1'b0, 3'd1, 1'b1, 1'b1, 3'b000, 3'b000);

      // Single-cycle load-to-use bubble.
      step(); load_to_use_i = 1'b1; samp();
      exp_ctl("load_to_use", 1'b0, 3'd1, 1'b1, 1'b0, 3'b001, 3'b110);
      step(); load_to_use_i = 1'b0; samp();
      exp_ctl("after_load_to_use", 1'b0, 3'd1, 1'b1, 1'b1, 3'b000, 3'b000);

      // EX busy for three cycles holds back a pending jump.
      for (int c = 0; c < 3; c++) begin
         step(); ex_ready_i = 1'b0; id_jump_i = 1'b1; samp();
         exp_ctl($sformatf("ex_busy_%0d", c), 1'b0, 3'd1, 1'b1, 1'b0, 3'b000, 3'b111);
      end
      step(); ex_ready_i = 1'b1; samp();
      exp_ctl("deferred_jump", 1'b1, 3'd2, 1'b1, 1'b0, 3'b110, 3'b000);
      check("three_halts_no_timeout", 32'(stall_timeout_o), 32'd0);
      step(); idle_in(); samp();
      step(); samp();
      exp_ctl("jump_back_to_decode", 1'b0, 3'd1, 1'b1, 1'b1, 3'b000, 3'b000);

      // Watchdog trips after four halts; trap overrides the halt.
      for (int c = 0; c < MAX_STALL; c++) begin
         step(); ex_ready_i = 1'b0; samp();
         check($sformatf("wd_not_yet_%0d", c), 32'(stall_timeout_o), 32'd0);
      end
      step(); samp();
      check("wd_tripped", 32'(stall_timeout_o), 32'd1);
      step(); trap_i = 1'b1; samp();
      exp_ctl("trap_in_halt", 1'b1, 3'd4, 1'b1, 1'b0, 3'b111, 3'b000);
      // In WAIT_FETCH, branch and jump are ignored but a trap is still taken.
      step(); trap_i = 1'b1; ex_ready_i = 1'b1; id_jump_i = 1'b1; ex_br_taken_i = 1'b1; samp();
      exp_ctl("trap_in_wait", 1'b1, 3'd4, 1'b1, 1'b0, 3'b111, 3'b000);
      step(); trap_i = 1'b0; samp();
      exp_ctl("wait_ignores_redirects", 1'b0, 3'd1, 1'b1, 1'b0, 3'b000, 3'b000);
      check("wd_sticky", 32'(stall_timeout_o), 32'd1);

      // Mid-operation reset clears everything and reboots.
      boot("reboot");

      for (int i = 0; i < 6; i++) begin
         rs1_hit_i = fwd_tab[i].h1;
         rs2_hit_i = fwd_tab[i].h2;
         #1;
         check($sformatf("fwd_rs1_%0d", i), 32'(rs1_fwd_sel_o), 32'(fwd_tab[i].e1));
         check($sformatf("fwd_rs2_%0d", i), 32'(rs2_fwd_sel_o), 32'(fwd_tab[i].e2));
      end

      // Randomized run against the behavioural model.
      m_phase = 0;
      m_run   = 0;
      m_to    = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         step();
         rst              = (i < 2) ? 1'b0 : ($urandom_range(199) != 0);
         if_fetch_valid_i = ($urandom_range(3) != 0);
         id_ready_i       = ($urandom_range(3) != 0);
         id_jump_i        = ($urandom_range(7) == 0);
         ex_br_taken_i    = ($urandom_range(7) == 0);
         ex_ready_i       = ($urandom_range(3) != 0);
         trap_i           = ($urandom_range(15) == 0);
         load_to_use_i    = ($urandom_range(5) == 0);
         rs1_hit_i        = 3'($urandom_range(7));
         rs2_hit_i        = 3'($urandom_range(7));
         if (!rst) begin
            m_phase = 0;
            m_run   = 0;
            m_to    = 1'b0;
         end
         predict(e);
         samp();
         check($sformatf("rand_%0d", i), 32'(dut_o), 32'(e));
         advance(e);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gs_pipe_ctrl.md
# gs_pipe_ctrl

Parametrised pipeline control unit for the GoldenSnitch in-order core. It sequences boot and fetch and redirects the PC on branch, jump and trap. It generates per-stage flush and halt controls for load-to-use and multi-cycle execute stalls. It also resolves operand forwarding across a configurable number of forwarding stages, and provides a stall watchdog.

## Interface
- NUM_FWD, 2, forwarding source stages (index 0 = youngest, e.g. EX; 1 = WB); range 1..7
- FWD_SEL_W, $clog2(NUM_FWD+1), derived; width of forward selects
- MAX_STALL, 64, consecutive halt cycles that trip the watchdog; ≥1
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- if_fetch_valid_i  in  1  IF holds a valid instruction
- id_ready_i  in  1  ID can accept an instruction
- id_jump_i  in  1  unconditional jump decoded in ID
- ex_br_taken_i  in  1  branch resolved taken in EX; valid only when ex_ready_i=1
- ex_ready_i  in  1  EX result complete this cycle
- trap_i  in  1  exception or interrupt request
- load_to_use_i  in  1  ID operand depends on a load in EX
- rs1_hit_i  in  NUM_FWD  rs1 matches the destination of stage k
- rs2_hit_i  in  NUM_FWD  rs2 matches the destination of stage k
- rs1_fwd_sel_o  out  FWD_SEL_W  0 = register file, k+1 = stage k
- rs2_fwd_sel_o  out  FWD_SEL_W  same encoding as rs1_fwd_sel_o
- pc_mux_sel_o  out  3  0 BOOT, 1 NORMAL, 2 JUMP, 3 BRANCH, 4 TRAP
- pc_set_o  out  1  one-cycle pulse: load the PC from pc_mux_sel_o
- instr_fetch_o  out  1  enable the fetch unit
- is_decoding_o  out  1  ID is issuing normally this cycle
- flush_if_o, flush_id_o, flush_ex_o  out  1 each  squash stage contents
- halt_if_o, halt_id_o, halt_ex_o  out  1 each  hold stage registers
- stall_timeout_o  out  1  sticky watchdog flag

## Operation
- FSM states: RESET → BOOT_SET → WAIT_FETCH ⇄ DECODE.
  - RESET: pc_mux_sel_o=BOOT. Next state is always BOOT_SET.
  - BOOT_SET: pc_set_o=1, pc_mux_sel_o=BOOT, instr_fetch_o=1. Next state is WAIT_FETCH.
  - WAIT_FETCH: instr_fetch_o=1. Go to DECODE when if_fetch_valid_i && id_ready_i.
- DECODE has instr_fetch_o=1. Actions in priority order:
  1. trap_i: pc_set_o=1, pc_mux_sel_o=TRAP, flush IF/ID/EX. Go to WAIT_FETCH.
  2. ex_br_taken_i && ex_ready_i: pc_set_o=1, pc_mux_sel_o=BRANCH, flush IF/ID. Go to WAIT_FETCH.
  3. id_jump_i with no active stall: pc_set_o=1, pc_mux_sel_o=JUMP, flush IF/ID. Go to WAIT_FETCH.
  4. Otherwise: pc_mux_sel_o=NORMAL, is_decoding_o=1 unless stalled. Stay in DECODE.
- Stall rules, active in DECODE only:
  - !ex_ready_i: halt IF/ID/EX.
  - Else if load_to_use_i: halt IF/ID and assert flush_ex_o to insert a bubble.
  - A redirect (priority 1 or 2) overrides both stalls: all halts are 0 that cycle.
  - A jump under an active stall is deferred until the stall clears.
- Defaults: all flush, halt and pc_set outputs are 0; pc_mux_sel_o=NORMAL outside RESET/BOOT_SET.
- Forwarding (purely combinational, independent of FSM state):
  - rsN_fwd_sel_o = k+1 for the lowest k with rsN_hit_i[k]=1, else 0.
- Watchdog:
  - Counter of width $clog2(MAX_STALL+1) increments each cycle any halt_*_o=1 and clears on any non-halt cycle.
  - Counter saturates at MAX_STALL.
  - stall_timeout_o sets on the cycle the count reaches MAX_STALL and stays set until reset.

## Timing
- All outputs except stall_timeout_o are combinational (Mealy) from the state register and inputs.
- stall_timeout_o is registered.
- Reset (rst=0): state=RESET, counter=0, stall_timeout_o=0. Outputs in RESET: pc_mux_sel_o=0, all other control outputs 0.
- First pc_set_o appears in the 2nd cycle after rst deasserts.
- First is_decoding_o appears no earlier than the 4th cycle.
- Redirect latency: pc_set_o is in the same cycle as the trigger. The FSM is in WAIT_FETCH the next cycle.
- Inputs in WAIT_FETCH other than fetch valid/ready are ignored. A trap is the exception and is taken from WAIT_FETCH with the same outputs as in DECODE.
- rst asserted mid-operation returns to RESET immediately. No pc_set_o is issued until BOOT_SET.

## Test plan
- Boot: release rst; valid=ready=1 from cycle 0 → pc_set_o=1 with pc_mux_sel_o=0 in cycle 2; is_decoding_o=1 from cycle 4.
- Branch versus jump: in DECODE, ex_br_taken_i=1, ex_ready_i=1, id_jump_i=1 → pc_mux_sel_o=3, flush_if_o=flush_id_o=1, flush_ex_o=0, next state WAIT_FETCH.
- Load-to-use: load_to_use_i=1 for 1 cycle → halt_if_o=halt_id_o=1, flush_ex_o=1, halt_ex_o=0, is_decoding_o=0; the next cycle is normal.
- EX busy plus deferred jump: ex_ready_i=0 for 3 cycles with id_jump_i=1 → 3 cycles of halt on all stages, no pc_set_o; the JUMP redirect occurs on the 4th cycle.
- Forwarding (NUM_FWD=3): rs1_hit_i=3'b110, rs2_hit_i=3'b000 → rs1_fwd_sel_o=2, rs2_fwd_sel_o=0; rs1_hit_i=3'b001 → rs1_fwd_sel_o=1.
- Watchdog (MAX_STALL=4): ex_ready_i=0 held → stall_timeout_o=1 after the 4th halt cycle; it remains 1 after ex_ready_i returns to 1; trap_i during a halt redirects to TRAP with halts at 0.
